input_manager: RTL

- Receive-side counterpart of output_manager. Deserializes UART_RX bytes into a circular byte queue.
- Serves the core's READI/READF path. On request, it pops 4 bytes big-endian and returns one 32-bit word.
- Sits beside output_manager in CPU. It is independent of program_loader, which owns UART_RX only while need_program_load is high.

---
 rtl/input_manager_pkg.sv | 9 +
 rtl/uart_rx_core.sv | 102 ++++++++++
 rtl/input_manager.sv | 119 +++++++++++
 3 files changed

// File: rtl/input_manager_pkg.sv
// Shared types and constants for the UART receive path and the word assembler.
package input_manager_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic {W_IDLE, W_COLLECT} word_state_t;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop synchronizer plus bit-sampling FSM. Emits one-cycle
// push and frame_err strobes; data is valid while push is high.
//   state | meaning
//   IDLE  | line idle, waiting for a low level while enabled
//   START | half-bit wait, then confirm the start bit (reject glitches)
//   DATA  | sample 8 data bits, one per bit period, LSB first
//   STOP  | sample the stop bit; high pushes the byte, low flags a frame error
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  input  logic       enable,
  output logic [7:0] data,
  output logic       push,
  output logic       frame_err
);
  import input_manager_pkg::*;

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);

  logic          sync_a;
  logic          rx;
  rx_state_t     state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b1;
      rx     <= 1'b1;
    end else begin
      sync_a <= uart_rx;
      rx     <= sync_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      push      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      push      <= 1'b0;
      frame_err <= 1'b0;
      // Loss of enable abandons any partial frame silently.
      if (!enable) begin
        state   <= IDLE;
        clk_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (!rx) begin
              state   <= START;
              clk_cnt <= '0;
            end
          end
          START: begin
            if (clk_cnt == HALF_TC) begin
              clk_cnt <= '0;
              bit_idx <= '0;
              state   <= rx ? IDLE : DATA;
            end else begin
              clk_cnt <= clk_cnt + CW'(1);
            end
          end
          DATA: begin
            if (clk_cnt == BIT_TC) begin
              clk_cnt        <= '0;
              shift[bit_idx] <= rx;
              if (bit_idx == 3'd7) state <= STOP;
              else bit_idx <= bit_idx + 3'd1;
            end else begin
              clk_cnt <= clk_cnt + CW'(1);
            end
          end
          STOP: begin
            if (clk_cnt == BIT_TC) begin
              clk_cnt <= '0;
              state   <= IDLE;
              if (rx) push <= 1'b1;
              else frame_err <= 1'b1;
            end else begin
              clk_cnt <= clk_cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign data = shift;

endmodule

// File: rtl/input_manager.sv
// Receive-side byte queue feeding the core's READI/READF path: UART bytes go into a
// circular queue; each word request pops four bytes, first-received in bits [31:24].
//   state     | meaning
//   W_IDLE    | waiting for WORD_REQ
//   W_COLLECT | popping bytes into the word, stalling while the queue is empty
module input_manager #(
  parameter int CLKS_PER_BIT = 868,
  parameter int QUEUE_AW     = 9
) (
  input  logic                CLK,
  input  logic                INITIALIZE_N,
  input  logic                UART_RX,
  input  logic                ENABLE,
  input  logic                WORD_REQ,
  output logic                WORD_VALID,
  output logic [31:0]         WORD_DATA,
  output logic                BUSY,
  output logic [QUEUE_AW-1:0] QUEUE_COUNT,
  output logic                OVERRUN,
  output logic                FRAME_ERR
);
  import input_manager_pkg::*;

  localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

  logic [7:0]          rx_byte;
  logic                rx_push;
  logic                rx_ferr;
  logic [7:0]          mem [2**QUEUE_AW];
  logic [QUEUE_AW-1:0] wr_ptr;
  logic [QUEUE_AW-1:0] rd_ptr;
  logic [QUEUE_AW-1:0] wr_next;
  logic                full;
  logic                empty;
  logic                push_ok;
  logic                pop;
  logic [7:0]          pop_byte;
  word_state_t         wstate;
  logic [1:0]          byte_idx;
  logic [23:0]         asm_hi;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (CLK),
    .rst_n     (INITIALIZE_N),
    .uart_rx   (UART_RX),
    .enable    (ENABLE),
    .data      (rx_byte),
    .push      (rx_push),
    .frame_err (rx_ferr)
  );

  // One slot stays unused so full and empty remain distinguishable.
  assign wr_next     = wr_ptr + QUEUE_AW'(1);
  assign full        = (wr_next == rd_ptr);
  assign empty       = (wr_ptr == rd_ptr);
  assign push_ok     = rx_push && !full;
  assign pop         = (wstate == W_COLLECT) && !empty;
  assign pop_byte    = mem[rd_ptr];
  assign QUEUE_COUNT = wr_ptr - rd_ptr;

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= rx_byte;
  end

  always_ff @(posedge CLK or negedge INITIALIZE_N) begin
    if (!INITIALIZE_N) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      OVERRUN   <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_next;
      if (pop) rd_ptr <= rd_ptr + QUEUE_AW'(1);
      if (rx_push && full) OVERRUN <= 1'b1;
      if (rx_ferr) FRAME_ERR <= 1'b1;
    end
  end

  // The first three bytes build up in asm_hi so WORD_DATA only changes on completion.
  always_ff @(posedge CLK or negedge INITIALIZE_N) begin
    if (!INITIALIZE_N) begin
      wstate     <= W_IDLE;
      byte_idx   <= '0;
      asm_hi     <= '0;
      WORD_DATA  <= '0;
      WORD_VALID <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      WORD_VALID <= 1'b0;
      case (wstate)
        W_IDLE: begin
          BUSY <= WORD_REQ;
          if (WORD_REQ) begin
            wstate   <= W_COLLECT;
            byte_idx <= '0;
          end
        end
        W_COLLECT: begin
          if (!empty) begin
            if (byte_idx == LAST_IDX) begin
              WORD_DATA  <= {asm_hi, pop_byte};
              WORD_VALID <= 1'b1;
              wstate     <= W_IDLE;
            end else begin
              case (byte_idx)
                2'd0:    asm_hi[23:16] <= pop_byte;
                2'd1:    asm_hi[15:8]  <= pop_byte;
                default: asm_hi[7:0]   <= pop_byte;
              endcase
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

endmodule
